timer_field_counter: RTL and testbench

Parametrised single-digit-field counter for the chronometer/timer datapath, the successor to the fixed 0–59 seconds counter. One instance holds one time field (seconds, minutes, hours) with a configurable modulus. It supports user adjustment through the up/down buttons with selectable wrap or saturate, and a run mode that counts down on a timebase tick. Instances chain through borrow/nonzero signals to build a full countdown timer. Its output feeds the display/RTC formatting logic.

---
 rtl/timer_field_counter_if.sv | 27 ++
 rtl/timer_field_counter.sv | 96 +++++++++
 tb/tb_timer_field_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_field_counter_if.sv
// Signal bundle between the mode FSM / chain neighbours and one timer field.
// The master side drives buttons, mode and chain inputs; the field drives value and flags.
interface timer_field_counter_if #(
    parameter int WIDTH = 6
);
    logic [1:0]       EN;
    logic             aumento;
    logic             disminuye;
    logic             clear;
    logic             run;
    logic             tick;
    logic             upper_nonzero;
    logic [WIDTH-1:0] value;
    logic             borrow_out;
    logic             nonzero_out;
    logic             done;

    modport master (
        output EN, aumento, disminuye, clear, run, tick, upper_nonzero,
        input  value, borrow_out, nonzero_out, done
    );

    modport slave (
        input  EN, aumento, disminuye, clear, run, tick, upper_nonzero,
        output value, borrow_out, nonzero_out, done
    );
endinterface

// File: rtl/timer_field_counter.sv
// One time field (seconds/minutes/hours) with button editing and chained countdown.
// Fields chain by feeding borrow_out into the next field's tick and nonzero_out downward.
module timer_field_counter #(
    parameter int WIDTH    = 6,
    parameter int MAX      = 59,
    parameter int SEL_CODE = 2,
    parameter int WRAP     = 1
) (
    input logic                  clk,
    input logic                  rst,
    timer_field_counter_if.slave bus
);
    if (MAX < 1 || MAX >= (1 << WIDTH)) begin : g_bad_max
        $error("timer_field_counter: MAX must satisfy 1 <= MAX < 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [1:0]       SEL_V = 2'(SEL_CODE);

    logic             aum_q;
    logic             dis_q;
    logic [WIDTH-1:0] value_q;
    logic             borrow_q;
    logic             done_q;

    logic [WIDTH-1:0] value_d;
    logic             borrow_d;
    logic             done_d;
    logic             up_step;
    logic             dn_step;
    logic             selected;

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        if (v == MAX_V) return (WRAP != 0) ? '0 : MAX_V;
        return v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        if (v == '0) return (WRAP != 0) ? MAX_V : '0;
        return v - 1'b1;
    endfunction

    assign up_step  = bus.aumento & ~aum_q;
    assign dn_step  = bus.disminuye & ~dis_q;
    assign selected = (bus.EN == SEL_V);

    // Next-state: clear beats edit, and a selected field ignores countdown ticks entirely.
    always_comb begin
        value_d  = value_q;
        borrow_d = 1'b0;
        done_d   = done_q;
        if (bus.clear) begin
            value_d = '0;
            done_d  = 1'b0;
        end else if (selected) begin
            if (up_step && !dn_step) begin
                value_d = step_up(value_q);
                done_d  = 1'b0;
            end else if (dn_step && !up_step) begin
                value_d = step_down(value_q);
                done_d  = 1'b0;
            end
        end else if (bus.run && bus.tick) begin
            if (value_q != '0) begin
                value_d = value_q - 1'b1;
            end else if (bus.upper_nonzero) begin
                value_d  = MAX_V;
                borrow_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    // Edge registers reset high so a button held through reset cannot step.
    always_ff @(posedge clk) begin
        if (rst) begin
            aum_q    <= 1'b1;
            dis_q    <= 1'b1;
            value_q  <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            aum_q    <= bus.aumento;
            dis_q    <= bus.disminuye;
            value_q  <= value_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.borrow_out  = borrow_q;
    assign bus.done        = done_q;
    assign bus.nonzero_out = (value_q != '0) | bus.upper_nonzero;
endmodule

// File: tb/tb_timer_field_counter.sv
// Bench for timer_field_counter: a seconds/minutes chain plus a saturating field,
// checked against an arithmetic reference model under directed and random stimulus.
module tb_timer_field_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en = 2'd0;
    logic       aum = 1'b0;
    logic       dis = 1'b0;
    logic       clr = 1'b0;
    logic       run = 1'b0;
    logic       tick = 1'b0;
    logic       unz_sat = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_field_counter_if #(.WIDTH(6)) sec_if ();
    timer_field_counter_if #(.WIDTH(6)) min_if ();
    timer_field_counter_if #(.WIDTH(6)) sat_if ();

    assign sec_if.EN = en;  assign min_if.EN = en;  assign sat_if.EN = en;
    assign sec_if.aumento = aum;  assign min_if.aumento = aum;  assign sat_if.aumento = aum;
    assign sec_if.disminuye = dis;  assign min_if.disminuye = dis;  assign sat_if.disminuye = dis;
    assign sec_if.clear = clr;  assign min_if.clear = clr;  assign sat_if.clear = clr;
    assign sec_if.run = run;  assign min_if.run = run;  assign sat_if.run = run;
    assign sec_if.tick = tick;
    assign min_if.tick = sec_if.borrow_out;
    assign sat_if.tick = tick;
    assign sec_if.upper_nonzero = min_if.nonzero_out;
    assign min_if.upper_nonzero = 1'b0;
    assign sat_if.upper_nonzero = unz_sat;

    timer_field_counter #(.WIDTH(6), .MAX(59), .SEL_CODE(2), .WRAP(1)) u_sec (
        .clk(clk), .rst(rst), .bus(sec_if.slave));
    timer_field_counter #(.WIDTH(6), .MAX(59), .SEL_CODE(1), .WRAP(1)) u_min (
        .clk(clk), .rst(rst), .bus(min_if.slave));
    timer_field_counter #(.WIDTH(6), .MAX(59), .SEL_CODE(2), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .bus(sat_if.slave));

    typedef struct {
        int v;
        bit done;
        bit borrow;
        bit aq;
        bit dq;
    } fld_t;

    fld_t ms = '{0, 0, 0, 1, 1};
    fld_t mm = '{0, 0, 0, 1, 1};
    fld_t mt = '{0, 0, 0, 1, 1};

    // Reference: one rising edge of a field, straight from the behavioural rules.
    function automatic fld_t fstep(fld_t s, int mx, bit wrap, bit sel, bit unz, bit tk);
        fld_t n;
        bit   up;
        bit   dn;
        n = s;
        up = aum && !s.aq;
        dn = dis && !s.dq;
        n.borrow = 0;
        n.aq = aum;
        n.dq = dis;
        if (rst) begin
            n.v = 0; n.done = 0; n.aq = 1; n.dq = 1;
        end else if (clr) begin
            n.v = 0; n.done = 0;
        end else if (sel) begin
            if (up != dn) begin
                n.done = 0;
                if (up) n.v = wrap ? (s.v + 1) % (mx + 1) : ((s.v < mx) ? s.v + 1 : mx);
                else    n.v = wrap ? (s.v + mx) % (mx + 1) : ((s.v > 0) ? s.v - 1 : 0);
            end
        end else if (run && tk) begin
            if (s.v > 0) n.v = s.v - 1;
            else if (unz) begin n.v = mx; n.borrow = 1; end
            else n.done = 1;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        fld_t ns, nm, nt;
        ns = fstep(ms, 59, 1, en == 2'd2, mm.v != 0, tick);
        nm = fstep(mm, 59, 1, en == 2'd1, 1'b0, ms.borrow);
        nt = fstep(mt, 59, 0, en == 2'd2, unz_sat, tick);
        @(posedge clk);
        ms = ns; mm = nm; mt = nt;
        #1;
        check("sec_value", 32'(sec_if.value), ms.v);
        check("sec_borrow", 32'(sec_if.borrow_out), ms.borrow);
        check("sec_done", 32'(sec_if.done), ms.done);
        check("sec_nonzero", 32'(sec_if.nonzero_out), (ms.v != 0 || mm.v != 0));
        check("min_value", 32'(min_if.value), mm.v);
        check("min_borrow", 32'(min_if.borrow_out), mm.borrow);
        check("min_done", 32'(min_if.done), mm.done);
        check("sat_value", 32'(sat_if.value), mt.v);
        check("sat_borrow", 32'(sat_if.borrow_out), mt.borrow);
        check("sat_done", 32'(sat_if.done), mt.done);
    endtask

    task automatic press_up(input int n);
        repeat (n) begin aum = 1'b1; step(); aum = 1'b0; step(); end
    endtask

    task automatic press_dn(input int n);
        repeat (n) begin dis = 1'b1; step(); dis = 1'b0; step(); end
    endtask

    task automatic pulse_clear();
        clr = 1'b1; step(); clr = 1'b0; step();
    endtask

    initial begin
        // Reset with aumento held high; release must not produce a step.
        aum = 1'b1; rst = 1'b1;
        step();
        check("rst_value", 32'(sec_if.value), 0);
        check("rst_done", 32'(sec_if.done), 0);
        check("rst_borrow", 32'(sec_if.borrow_out), 0);
        rst = 1'b0;
        step(); step();
        check("held_through_rst", 32'(sec_if.value), 0);
        aum = 1'b0; step();

        en = 2'd2;
        press_up(1);
        check("edit_up_1", 32'(sec_if.value), 1);
        press_dn(2);
        check("wrap_down_59", 32'(sec_if.value), 59);
        check("sat_floor_0", 32'(sat_if.value), 0);
        press_up(1);
        check("wrap_up_0", 32'(sec_if.value), 0);

        pulse_clear();
        press_up(59);
        check("sat_reach_59", 32'(sat_if.value), 59);
        press_up(1);
        check("sat_ceiling_59", 32'(sat_if.value), 59);
        check("wrap_59_to_0", 32'(sec_if.value), 0);

        pulse_clear();
        press_up(5);
        aum = 1'b1;
        repeat (10) step();
        aum = 1'b0; step();
        check("hold_single_step", 32'(sat_if.value), 6);

        aum = 1'b1; dis = 1'b1; step();
        aum = 1'b0; dis = 1'b0; step();
        check("both_buttons", 32'(sec_if.value), 6);
        en = 2'd1;
        press_up(1);
        check("wrong_en_sec", 32'(sec_if.value), 6);
        check("min_edit", 32'(min_if.value), 1);

        // Countdown chain: min=1, sec=0.
        en = 2'd2;
        press_dn(6);
        en = 2'd0; run = 1'b1;
        tick = 1'b1; step();
        check("chain_sec_wrap", 32'(sec_if.value), 59);
        check("chain_borrow", 32'(sec_if.borrow_out), 1);
        check("chain_min_before", 32'(min_if.value), 1);
        tick = 1'b0; step();
        check("chain_min_after", 32'(min_if.value), 0);
        repeat (59) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        check("chain_sec_zero", 32'(sec_if.value), 0);
        check("chain_not_done", 32'(sec_if.done), 0);
        tick = 1'b1; step();
        check("chain_done", 32'(sec_if.done), 1);
        check("chain_sec_hold", 32'(sec_if.value), 0);
        check("chain_min_hold", 32'(min_if.value), 0);
        tick = 1'b0; run = 1'b0; step();

        en = 2'd2;
        press_up(1);
        check("edit_clears_done", 32'(sec_if.done), 0);
        clr = 1'b1; aum = 1'b1; step();
        check("clear_beats_edit", 32'(sec_if.value), 0);
        clr = 1'b0; aum = 1'b0; step();
        press_up(3);
        run = 1'b1; tick = 1'b1; step();
        tick = 1'b0; step();
        check("tick_ignored_in_edit", 32'(sec_if.value), 3);
        run = 1'b0;

        // Reset mid-run with a tick in the same cycle.
        pulse_clear();
        press_up(30);
        en = 2'd0; run = 1'b1; tick = 1'b1; rst = 1'b1;
        step();
        check("midrun_rst_value", 32'(sec_if.value), 0);
        check("midrun_rst_borrow", 32'(sec_if.borrow_out), 0);
        check("midrun_rst_done", 32'(sec_if.done), 0);
        rst = 1'b0; tick = 1'b0; run = 1'b0; step();

        repeat (3000) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 59) == 0);
            en      = 2'($urandom_range(0, 3));
            aum     = ($urandom_range(0, 2) == 0);
            dis     = ($urandom_range(0, 2) == 0);
            run     = ($urandom_range(0, 7) != 0);
            tick    = ($urandom_range(0, 2) == 0);
            unz_sat = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
